// File: rtl/fechadura_param.sv
// Parametrised digit-code lock. Keypad digits are compared against a stored
// code (reprogrammable at runtime). Failed attempts are counted and trigger a
// timed lockout. Partial entries are abandoned after an idle timeout. Status
// and a 7-segment glyph are Moore outputs of the registered state.
module fechadura_param #(
  parameter int unsigned N_DIGITS = 6,
  parameter int unsigned DIGIT_W = 4,
  parameter logic [N_DIGITS*DIGIT_W-1:0] CODIGO_INI = 24'h590981,
  parameter int unsigned MAX_TENT = 3,
  parameter int unsigned ERR_HOLD = 4,
  parameter int unsigned LOCK_CYCLES = 20,
  parameter int unsigned TIMEOUT = 50
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            insere,
  input  logic [DIGIT_W-1:0]              numero,
  input  logic                            programa,
  input  logic                            trava,
  output logic                            aberto,
  output logic                            erro,
  output logic                            bloqueado,
  output logic [$clog2(MAX_TENT+1)-1:0]   tentativas,
  output logic [6:0]                      seg
);

  localparam int unsigned CODE_W   = N_DIGITS * DIGIT_W;
  localparam int unsigned POS_W    = $clog2(N_DIGITS + 1);
  localparam int unsigned TENT_W   = $clog2(MAX_TENT + 1);
  localparam int unsigned HOLD_MAX = (ERR_HOLD > LOCK_CYCLES) ? ERR_HOLD : LOCK_CYCLES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int unsigned IDLE_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ABERTO, ERRO, BLOQUEIO, PROGRAMA} state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                mism_q, mism_d;
  logic [TENT_W-1:0]   tent_q, tent_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   newcode_q, newcode_d;

  logic [DIGIT_W-1:0]  cur_digit;
  logic                digit_bad;
  logic                last_digit;
  logic                idle_expired;
  logic [CODE_W-1:0]   shifted;
  logic [TENT_W-1:0]   tent_inc;

  // State and datapath registers; the stored code is volatile across reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      mism_q    <= 1'b0;
      tent_q    <= '0;
      hold_q    <= '0;
      idle_q    <= '0;
      code_q    <= CODIGO_INI;
      newcode_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      mism_q    <= mism_d;
      tent_q    <= tent_d;
      hold_q    <= hold_d;
      idle_q    <= idle_d;
      code_q    <= code_d;
      newcode_q <= newcode_d;
    end
  end

  // Next-state and datapath update for entry, hold timers and programming.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    mism_d    = mism_q;
    tent_d    = tent_q;
    hold_d    = hold_q;
    idle_d    = idle_q;
    code_d    = code_q;
    newcode_d = newcode_q;

    cur_digit = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (pos_q == POS_W'(i)) cur_digit = code_q[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
    digit_bad    = (numero > DIGIT_W'(9)) || (numero != cur_digit);
    last_digit   = (pos_q == POS_W'(N_DIGITS - 1));
    idle_expired = (idle_q == IDLE_W'(TIMEOUT - 1));
    shifted      = (newcode_q << DIGIT_W) | CODE_W'(numero);
    tent_inc     = (tent_q == TENT_W'(MAX_TENT)) ? tent_q : tent_q + TENT_W'(1);

    case (state_q)
      IDLE: begin
        if (insere) begin
          idle_d = '0;
          if (last_digit) begin
            pos_d  = '0;
            mism_d = 1'b0;
            hold_d = '0;
            if (!(mism_q || digit_bad)) begin
              state_d = ABERTO;
              tent_d  = '0;
            end else begin
              tent_d  = tent_inc;
              state_d = (tent_inc == TENT_W'(MAX_TENT)) ? BLOQUEIO : ERRO;
            end
          end else begin
            pos_d  = pos_q + POS_W'(1);
            mism_d = mism_q || digit_bad;
          end
        end else if (pos_q != '0) begin
          if (idle_expired) begin
            pos_d  = '0;
            mism_d = 1'b0;
            idle_d = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      ERRO: begin
        if (hold_q == HOLD_W'(ERR_HOLD - 1)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      BLOQUEIO: begin
        if (hold_q == HOLD_W'(LOCK_CYCLES - 1)) begin
          state_d = IDLE;
          hold_d  = '0;
          tent_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ABERTO: begin
        if (trava) begin
          state_d = IDLE;
          pos_d   = '0;
          idle_d  = '0;
        end else if (programa) begin
          state_d   = PROGRAMA;
          newcode_d = '0;
          pos_d     = '0;
          idle_d    = '0;
        end
      end
      PROGRAMA: begin
        if (trava) begin
          state_d = IDLE;
          pos_d   = '0;
          idle_d  = '0;
        end else if (insere) begin
          idle_d = '0;
          if (numero > DIGIT_W'(9)) begin
            state_d = ABERTO;
            pos_d   = '0;
          end else if (last_digit) begin
            code_d    = shifted;
            newcode_d = shifted;
            state_d   = ABERTO;
            pos_d     = '0;
          end else begin
            newcode_d = shifted;
            pos_d     = pos_q + POS_W'(1);
          end
        end else if (pos_q != '0) begin
          if (idle_expired) begin
            state_d = ABERTO;
            pos_d   = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state and entry position.
  always_comb begin
    aberto     = (state_q == ABERTO) || (state_q == PROGRAMA);
    erro       = (state_q == ERRO);
    bloqueado  = (state_q == BLOQUEIO);
    tentativas = tent_q;
    seg        = 7'b0000000;
    case (state_q)
      IDLE: begin
        case (pos_q)
          POS_W'(0): seg = 7'b1111110;
          POS_W'(1): seg = 7'b0110000;
          POS_W'(2): seg = 7'b1101101;
          POS_W'(3): seg = 7'b1111001;
          POS_W'(4): seg = 7'b0110011;
          POS_W'(5): seg = 7'b1011011;
          POS_W'(6): seg = 7'b1011111;
          POS_W'(7): seg = 7'b1110000;
          POS_W'(8): seg = 7'b1111111;
          default:   seg = 7'b1111011;
        endcase
      end
      ABERTO:   seg = 7'b1110111;
      ERRO:     seg = 7'b1001111;
      BLOQUEIO: seg = 7'b0001110;
      PROGRAMA: seg = 7'b1100111;
      default:  seg = 7'b0000000;
    endcase
  end

endmodule

// File: tb/tb_fechadura_param.sv
// Self-checking bench for fechadura_param: directed scenarios plus a random
// phase, every cycle compared against a sequence-level reference model.
module tb_fechadura_param;

  localparam int unsigned N  = 6;
  localparam int unsigned MT = 3;
  localparam int unsigned EH = 4;
  localparam int unsigned LC = 20;
  localparam int unsigned TO = 50;
  localparam logic [23:0] CINI = 24'h590981;

  logic       clk = 1'b0;
  logic       reset;
  logic       insere;
  logic [3:0] numero;
  logic       programa;
  logic       trava;
  logic       aberto;
  logic       erro;
  logic       bloqueado;
  logic [1:0] tentativas;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  fechadura_param #(
    .N_DIGITS(N), .DIGIT_W(4), .CODIGO_INI(CINI), .MAX_TENT(MT),
    .ERR_HOLD(EH), .LOCK_CYCLES(LC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .insere(insere), .numero(numero),
    .programa(programa), .trava(trava), .aberto(aberto), .erro(erro),
    .bloqueado(bloqueado), .tentativas(tentativas), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: digits kept as whole sequences, timers as countdowns.
  typedef enum {M_IDLE, M_OPEN, M_ERR, M_LOCK, M_PROG} mmode_t;
  mmode_t     mm;
  int         code[N];
  int         entered[$];
  int         newq[$];
  int         idle_cnt;
  int         hold;
  int         fails;
  logic [6:0] pat[10];

  function automatic void model_reset();
    logic [23:0] c;
    c = CINI;
    mm = M_IDLE;
    for (int i = 0; i < N; i++) code[i] = int'(c[(N-1-i)*4 +: 4]);
    entered.delete();
    newq.delete();
    idle_cnt = 0;
    hold = 0;
    fails = 0;
  endfunction

  function automatic void model_step(input bit ins, input int num, input bit prog, input bit trv);
    bit ok;
    case (mm)
      M_IDLE: begin
        if (ins) begin
          idle_cnt = 0;
          entered.push_back(num);
          if (entered.size() == N) begin
            ok = 1;
            for (int i = 0; i < N; i++) if (entered[i] != code[i]) ok = 0;
            entered.delete();
            if (ok) begin
              mm = M_OPEN;
              fails = 0;
            end else begin
              fails++;
              if (fails == MT) begin mm = M_LOCK; hold = LC; end
              else begin mm = M_ERR; hold = EH; end
            end
          end
        end else if (entered.size() > 0) begin
          idle_cnt++;
          if (idle_cnt == TO) begin entered.delete(); idle_cnt = 0; end
        end
      end
      M_ERR: begin
        hold--;
        if (hold == 0) mm = M_IDLE;
      end
      M_LOCK: begin
        hold--;
        if (hold == 0) begin mm = M_IDLE; fails = 0; end
      end
      M_OPEN: begin
        if (trv) mm = M_IDLE;
        else if (prog) begin mm = M_PROG; newq.delete(); idle_cnt = 0; end
      end
      M_PROG: begin
        if (trv) begin mm = M_IDLE; newq.delete(); idle_cnt = 0; end
        else if (ins) begin
          idle_cnt = 0;
          if (num > 9) begin mm = M_OPEN; newq.delete(); end
          else begin
            newq.push_back(num);
            if (newq.size() == N) begin
              for (int i = 0; i < N; i++) code[i] = newq[i];
              newq.delete();
              mm = M_OPEN;
            end
          end
        end else if (newq.size() > 0) begin
          idle_cnt++;
          if (idle_cnt == TO) begin mm = M_OPEN; newq.delete(); idle_cnt = 0; end
        end
      end
      default: mm = M_IDLE;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg();
    case (mm)
      M_IDLE:  return pat[entered.size()];
      M_OPEN:  return 7'b1110111;
      M_ERR:   return 7'b1001111;
      M_LOCK:  return 7'b0001110;
      default: return 7'b1100111;
    endcase
  endfunction

  task automatic check_outputs();
    check("aberto", 32'(aberto), 32'(mm == M_OPEN || mm == M_PROG));
    check("erro", 32'(erro), 32'(mm == M_ERR));
    check("bloqueado", 32'(bloqueado), 32'(mm == M_LOCK));
    check("tentativas", 32'(tentativas), 32'(fails));
    check("seg", 32'(seg), 32'(exp_seg()));
  endtask

  task automatic cycle(input bit ins, input int num, input bit prog, input bit trv);
    insere = ins; numero = num[3:0]; programa = prog; trava = trv;
    @(posedge clk);
    model_step(ins, num, prog, trv);
    @(negedge clk);
    insere = 1'b0; programa = 1'b0; trava = 1'b0;
    check_outputs();
  endtask

  task automatic enter_code(input logic [23:0] c);
    for (int i = 0; i < N; i++) cycle(1'b1, int'(c[(N-1-i)*4 +: 4]), 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_aberto"}, 32'(aberto), 32'd0);
    check({tag, "_erro"}, 32'(erro), 32'd0);
    check({tag, "_bloq"}, 32'(bloqueado), 32'd0);
    check({tag, "_tent"}, 32'(tentativas), 32'd0);
    check({tag, "_seg"}, 32'(seg), 32'b1111110);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int cnt;
    int r;
    int num;
    pat = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    reset = 1'b0; insere = 1'b0; numero = '0; programa = 1'b0; trava = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;

    // Correct code opens one cycle after the last strobe.
    enter_code(24'h590981);
    check("open_aberto", 32'(aberto), 32'd1);
    check("open_seg", 32'(seg), 32'b1110111);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Single failure: erro held exactly ERR_HOLD cycles.
    enter_code(24'h590982);
    cnt = int'(erro);
    for (int i = 0; i < 5; i++) begin idle(1); cnt += int'(erro); end
    check("err_hold_len", 32'(cnt), 32'd4);
    check("err_tent", 32'(tentativas), 32'd1);
    check("err_back_idle", 32'(seg), 32'b1111110);

    // Lockout after third failure; correct code during lockout is ignored.
    enter_code(24'h111111); idle(5);
    enter_code(24'h222222);
    cnt = int'(bloqueado);
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, int'(CINI[(N-1-i)*4 +: 4]), 1'b0, 1'b0);
      cnt += int'(bloqueado);
    end
    for (int i = 0; i < 14; i++) begin idle(1); cnt += int'(bloqueado); end
    check("lock_len", 32'(cnt), 32'd20);
    check("lock_tent_clr", 32'(tentativas), 32'd0);
    enter_code(CINI);
    check("post_lock_open", 32'(aberto), 32'd1);
    cycle(1'b0, 0, 1'b1, 1'b1);
    check("trava_beats_prog", 32'(aberto), 32'd0);

    // Invalid digit: failure reported only after the full sequence.
    enter_code(24'h59C981);
    check("inv_erro", 32'(erro), 32'd1);
    idle(5);
    cycle(1'b1, 5, 1'b0, 1'b0); cycle(1'b1, 9, 1'b0, 1'b0);
    idle(TO - 1);
    check("to_before", 32'(seg), 32'b1101101);
    idle(1);
    check("to_after", 32'(seg), 32'b1111110);
    check("to_tent", 32'(tentativas), 32'd1);

    // Reprogramming, then an aborted reprogramming with an invalid digit.
    enter_code(CINI);
    cycle(1'b0, 0, 1'b1, 1'b0);
    enter_code(24'h123456);
    check("prog_done", 32'(seg), 32'b1110111);
    cycle(1'b0, 0, 1'b0, 1'b1);
    enter_code(CINI);
    check("old_code_fails", 32'(erro), 32'd1);
    idle(5);
    enter_code(24'h123456);
    check("new_code_opens", 32'(aberto), 32'd1);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 7, 1'b0, 1'b0); cycle(1'b1, 7, 1'b0, 1'b0); cycle(1'b1, 10, 1'b0, 1'b0);
    check("abort_to_open", 32'(seg), 32'b1110111);
    cycle(1'b0, 0, 1'b0, 1'b1);
    enter_code(24'h123456);
    check("code_kept", 32'(aberto), 32'd1);

    // Async reset mid-PROGRAMA and mid-entry restores the reset code.
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 7, 1'b0, 1'b0); cycle(1'b1, 7, 1'b0, 1'b0);
    async_reset("rst_prog");
    cycle(1'b1, 1, 1'b0, 1'b0); cycle(1'b1, 2, 1'b0, 1'b0);
    async_reset("rst_entry");
    enter_code(CINI);
    check("rst_code_back", 32'(aberto), 32'd1);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Random phase biased toward the currently stored code.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) idle(int'($urandom_range(40, 60)));
      r = int'($urandom_range(0, 99));
      if (r < 10) num = int'($urandom_range(0, 15));
      else if (r < 25) num = int'($urandom_range(0, 9));
      else num = code[entered.size() % N];
      r = int'($urandom_range(0, 99));
      cycle(r < 45, num, (r >= 90 && r < 95), (r >= 97));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fechadura_param.md
Name: fechadura_param

Overview:
Parametrised digit-code lock. Accepts one BCD digit per `insere` strobe and compares a full N_DIGITS sequence against a stored code. Drives unlock, error and lockout status plus a 7-segment status display. Adds runtime code reprogramming, an attempt limit with timed lockout, and an entry timeout. Sits between the keypad/switch front end and the door actuator/display.

Parameters:
N_DIGITS, 6, code length in digits (1..9)
DIGIT_W, 4, digit input width; digit valid only if value <= 9
CODIGO_INI, 24'h590981, reset code, N_DIGITS*DIGIT_W bits, first digit in MSBs
MAX_TENT, 3, consecutive failures that trigger lockout (>=1)
ERR_HOLD, 4, cycles ERRO state is held
LOCK_CYCLES, 20, cycles BLOQUEIO state is held
TIMEOUT, 50, idle cycles allowed between digits mid-entry

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
insere  in  1  one-cycle digit-valid strobe
numero  in  DIGIT_W  digit value, sampled when insere=1
programa  in  1  in ABERTO: start entering a new code
trava  in  1  in ABERTO/PROGRAMA: relock
aberto  out  1  high in ABERTO and PROGRAMA
erro  out  1  high in ERRO
bloqueado  out  1  high in BLOQUEIO
tentativas  out  $clog2(MAX_TENT+1)  consecutive failure count
seg  out  7  {A,B,C,D,E,F,G}, active-high

Behaviour:
- Reset (reset=0, async) puts the block in:
  - state IDLE, pos=0, mismatch=0, tentativas=0, all timers 0
  - stored code = CODIGO_INI (code is volatile across reset)
  - aberto=erro=bloqueado=0, seg=1111110 ("0")
- All outputs are registered Moore outputs: they reflect state one cycle after the causing strobe.
- IDLE/entry:
  - On each insere: compare numero with stored digit[pos].
  - Set mismatch if the digit differs or numero>9.
  - pos++. Wrong-digit position is never revealed; entry always completes all N_DIGITS.
- On the N_DIGITS-th insere:
  - mismatch=0: go to ABERTO; tentativas=0.
  - mismatch=1: tentativas++. If the new value == MAX_TENT, go to BLOQUEIO; else go to ERRO.
  - pos and mismatch are cleared in either case.
- Entry timeout:
  - Applies only when pos>0 and no insere for TIMEOUT consecutive cycles.
  - Result: pos=0, mismatch=0, stay in IDLE. tentativas is unchanged and the timeout is not counted as a failure.
  - If insere arrives in the same cycle as timer expiry, insere wins and the timer restarts.
- ERRO: held ERR_HOLD cycles, then IDLE. insere is ignored.
- BLOQUEIO: held LOCK_CYCLES cycles, then IDLE with tentativas=0. insere, programa and trava are ignored.
- ABERTO:
  - trava: go to IDLE.
  - programa (trava=0): go to PROGRAMA, new-code buffer cleared, pos=0.
  - insere is ignored.
  - trava and programa in the same cycle: trava wins.
- PROGRAMA:
  - Each insere with numero<=9 shifts the digit into the buffer; pos++.
  - N_DIGITS-th valid digit: commit buffer to stored code in the same edge, go to ABERTO.
  - insere with numero>9: abort to ABERTO; stored code unchanged.
  - trava: abort to IDLE; code unchanged. trava beats a same-cycle insere.
  - TIMEOUT applies as in IDLE; expiry aborts to ABERTO.
- seg encoding:
  - IDLE: decimal pos, using patterns 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - ABERTO: "A"=1110111
  - ERRO: "E"=1001111
  - BLOQUEIO: "L"=0001110
  - PROGRAMA: "P"=1100111
- Counter widths: $clog2 of each bound plus 1. Counters saturate and never wrap.
- Mid-operation reset: immediate return to reset values in every state. A partially programmed code is discarded.

Test Plan:
- Correct code: reset, insere 5,9,0,9,8,1 on consecutive cycles -> aberto=1 and seg=1110111 one cycle after the 6th strobe; tentativas=0.
- Single failure: enter 5,9,0,9,8,2 -> erro=1 for exactly 4 cycles, seg=1001111, tentativas=1, then IDLE with seg=1111110.
- Lockout: three wrong entries -> after the 3rd, bloqueado=1 for 20 cycles and a correct code entered during lockout is ignored -> then IDLE with tentativas=0, and the correct code now opens.
- Invalid digit and timeout: insere numero=4'hC as the 3rd digit -> failure only after the 6th digit. Separately, enter 5,9 then idle 50 cycles -> pos=0, seg=1111110, tentativas unchanged.
- Reprogramming: open, pulse programa, insere 1,2,3,4,5,6 -> ABERTO. trava, then old code fails and 1,2,3,4,5,6 opens. Repeat with numero=4'hA mid-programming -> code unchanged.
- Async reset: assert reset=0 mid-entry and mid-PROGRAMA, off clock edge -> outputs reset immediately and stored code returns to 24'h590981.
